// File: rtl/nvme_admin_cmd_exec.sv
// nvme_admin_cmd_exec: builds one NVMe admin command in the admin SQ, rings the tail doorbell,
// polls the admin CQ for its completion and rings the head doorbell.
module nvme_admin_cmd_exec #(
    parameter int          ASQ_DEPTH = 8,
    parameter int          ACQ_DEPTH = 8,
    parameter logic [15:0] IO_QSIZE  = 16'd64,
    parameter logic [15:0] IO_QID    = 16'd1,
    parameter logic [63:0] IDENT_PRP = 64'h0000_0000_1000_0000,
    parameter logic [63:0] IOCQ_PRP  = 64'h0000_0000_2000_0000,
    parameter logic [63:0] IOSQ_PRP  = 64'h0000_0000_3000_0000,
    parameter logic [31:0] SQ0TDBL   = 32'h1000,
    parameter logic [31:0] CQ0HDBL   = 32'h1004,
    parameter logic [31:0] TIMEOUT   = 32'd1_000_000
) (
    input  logic        clk_in,
    input  logic        resetb,
    input  logic [31:0] config_data,
    input  logic [31:0] nsid,
    output logic        sq_wr_en,
    output logic [9:0]  sq_wr_addr,
    output logic [31:0] sq_wr_data,
    output logic        cq_rd_en,
    output logic [9:0]  cq_rd_addr,
    input  logic [31:0] cq_rd_data,
    output logic        db_wr_en,
    output logic [31:0] db_addr,
    output logic [31:0] db_data,
    output logic        seq_tail_done,
    output logic        seq_tail_done_ack,
    output logic        cmd_complete,
    output logic        cmd_complete_ack,
    output logic [14:0] cmd_status,
    output logic        cmd_error,
    output logic        busy
);
    localparam int SQW = $clog2(ASQ_DEPTH);
    localparam int CQW = $clog2(ACQ_DEPTH);

    typedef enum logic [2:0] {IDLE, BUILD, DOORBELL, POLL_RD, POLL_CHK, CQ_DB, DONE} state_t;
    state_t state, nxt;

    logic [31:0]    cfg_q, pend_code, nsid_q, tcnt, sel, dword;
    logic           pend, err_q, bad_q, cmp_q, tail_ack_q, phase;
    logic [2:0]     code;
    logic [3:0]     dw_cnt;
    logic [SQW-1:0] sq_tail, sq_tail_nx;
    logic [CQW-1:0] cq_head, cq_head_nx;
    logic [15:0]    cid;
    logic [14:0]    status_q;
    logic [7:0]     opcode;
    logic [63:0]    prp;
    logic           change, go, valid, start, accept, timed_out, ident_ns, ioq;

    assign change     = config_data != cfg_q && config_data != 32'd0;
    assign sel        = pend ? pend_code : config_data;
    assign go         = state == IDLE && (pend || change);
    assign valid      = sel >= 32'd1 && sel <= 32'd5;
    assign start      = go && valid;
    assign accept     = cq_rd_data[16] == phase && cq_rd_data[15:0] == cid;
    assign timed_out  = tcnt >= TIMEOUT;
    assign sq_tail_nx = sq_tail + SQW'(1);
    assign cq_head_nx = cq_head + CQW'(1);

    assign opcode   = code == 3'd4 ? 8'h05 : code == 3'd5 ? 8'h01 : 8'h06;
    assign prp      = code == 3'd4 ? IOCQ_PRP : code == 3'd5 ? IOSQ_PRP : IDENT_PRP;
    assign ident_ns = code == 3'd2 || code == 3'd3;
    assign ioq      = code == 3'd4 || code == 3'd5;
    assign dword    = dw_cnt == 4'd0  ? {cid, 8'h00, opcode} :
                      dw_cnt == 4'd1  ? (ident_ns ? nsid_q : 32'd0) :
                      dw_cnt == 4'd6  ? prp[31:0] :
                      dw_cnt == 4'd7  ? prp[63:32] :
                      dw_cnt == 4'd10 ? (code == 3'd1 ? 32'd1 : ioq ? {IO_QSIZE - 16'd1, IO_QID} : 32'd0) :
                      dw_cnt == 4'd11 ? (code == 3'd4 ? 32'd1 : code == 3'd5 ? {IO_QID, 16'h0001} : 32'd0) :
                      32'd0;

    assign sq_wr_addr        = sq_wr_en ? 10'({sq_tail, dw_cnt}) : 10'd0;
    assign sq_wr_data        = sq_wr_en ? dword : 32'd0;
    assign cq_rd_addr        = cq_rd_en ? 10'({cq_head, 2'b11}) : 10'd0;
    assign seq_tail_done     = state inside {POLL_RD, POLL_CHK, CQ_DB};
    assign seq_tail_done_ack = tail_ack_q;
    assign cmd_complete      = cmp_q || state == DONE;
    assign cmd_complete_ack  = state == DONE;
    assign cmd_status        = status_q;
    assign cmd_error         = err_q || bad_q;
    assign busy              = state != IDLE;

    always_ff @(posedge clk_in)
        if (resetb) state <= IDLE;
        else state <= nxt;

    always_comb begin
        nxt      = state;
        sq_wr_en = 1'b0;
        cq_rd_en = 1'b0;
        db_wr_en = 1'b0;
        db_addr  = 32'd0;
        db_data  = 32'd0;
        case (state)
            IDLE:     nxt = start ? BUILD : IDLE;
            BUILD: begin
                sq_wr_en = 1'b1;
                nxt      = dw_cnt == 4'd15 ? DOORBELL : BUILD;
            end
            DOORBELL: begin
                db_wr_en = 1'b1;
                db_addr  = SQ0TDBL;
                db_data  = 32'(sq_tail_nx);
                nxt      = POLL_RD;
            end
            POLL_RD: begin
                cq_rd_en = 1'b1;
                nxt      = POLL_CHK;
            end
            POLL_CHK: nxt = accept ? CQ_DB : timed_out ? DONE : POLL_RD;
            CQ_DB: begin
                db_wr_en = 1'b1;
                db_addr  = CQ0HDBL;
                db_data  = 32'(cq_head);
                nxt      = DONE;
            end
            DONE:     nxt = IDLE;
            default:  nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (resetb) begin
            cfg_q      <= 32'd0;
            pend       <= 1'b0;
            pend_code  <= 32'd0;
            nsid_q     <= 32'd0;
            code       <= 3'd0;
            dw_cnt     <= 4'd0;
            tcnt       <= 32'd0;
            sq_tail    <= '0;
            cq_head    <= '0;
            phase      <= 1'b1;
            cid        <= 16'd0;
            status_q   <= 15'd0;
            err_q      <= 1'b0;
            bad_q      <= 1'b0;
            cmp_q      <= 1'b0;
            tail_ack_q <= 1'b0;
        end else begin
            cfg_q      <= config_data;
            bad_q      <= go && !valid;
            tail_ack_q <= state == DOORBELL;
            // a change that cannot start right now is held until the next IDLE cycle
            if (change && !(state == IDLE && !pend)) begin
                pend      <= 1'b1;
                pend_code <= config_data;
            end else if (state == IDLE && pend) begin
                pend <= 1'b0;
            end
            if (start) begin
                code   <= sel[2:0];
                nsid_q <= nsid;
                dw_cnt <= 4'd0;
                tcnt   <= 32'd0;
                err_q  <= 1'b0;
                cmp_q  <= 1'b0;
            end
            if (state == BUILD) dw_cnt <= dw_cnt + 4'd1;
            if (state == DOORBELL) sq_tail <= sq_tail_nx;
            if (state == POLL_RD || state == POLL_CHK) tcnt <= tcnt + 32'd1;
            if (state == POLL_CHK && accept) begin
                status_q <= cq_rd_data[31:17];
                err_q    <= |cq_rd_data[31:17];
                cq_head  <= cq_head_nx;
                if (cq_head_nx == '0) phase <= ~phase;
            end else if (state == POLL_CHK && timed_out) begin
                status_q <= 15'h7FFF;
                err_q    <= 1'b1;
            end
            if (state == DONE) begin
                cmp_q <= 1'b1;
                cid   <= cid + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_nvme_admin_cmd_exec.sv
// tb_nvme_admin_cmd_exec: randomized admin commands against a queue-level model of the
// SQ/CQ rings; a negedge monitor pops expected SQ writes, doorbells and completions.
module tb_nvme_admin_cmd_exec;
    logic        clk_in = 1'b0, resetb = 1'b1;
    logic [31:0] config_data = 32'd0, nsid = 32'd0, cq_rd_data = 32'd0;
    logic        sq_wr_en, cq_rd_en, db_wr_en, seq_tail_done, seq_tail_done_ack;
    logic        cmd_complete, cmd_complete_ack, cmd_error, busy;
    logic [9:0]  sq_wr_addr, cq_rd_addr;
    logic [31:0] sq_wr_data, db_addr, db_data;
    logic [14:0] cmd_status;

    nvme_admin_cmd_exec #(.TIMEOUT(32'd100)) dut (
        .clk_in(clk_in), .resetb(resetb), .config_data(config_data), .nsid(nsid),
        .sq_wr_en(sq_wr_en), .sq_wr_addr(sq_wr_addr), .sq_wr_data(sq_wr_data),
        .cq_rd_en(cq_rd_en), .cq_rd_addr(cq_rd_addr), .cq_rd_data(cq_rd_data),
        .db_wr_en(db_wr_en), .db_addr(db_addr), .db_data(db_data),
        .seq_tail_done(seq_tail_done), .seq_tail_done_ack(seq_tail_done_ack),
        .cmd_complete(cmd_complete), .cmd_complete_ack(cmd_complete_ack),
        .cmd_status(cmd_status), .cmd_error(cmd_error), .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {logic [31:0] a; logic [31:0] d;} wr_t;
    typedef struct packed {logic [14:0] st; logic er;} done_t;
    wr_t   sq_q[$], db_q[$];
    done_t done_q[$];
    logic [31:0] cq_mem [1024];
    int vecs = 0, errs = 0;
    int m_tail = 0, m_head = 0, m_phase = 1, m_cid = 0;

    always @(posedge clk_in) if (cq_rd_en) cq_rd_data <= cq_mem[cq_rd_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected traffic for one command, from the ring arithmetic of the admin queues
    task automatic expect_cmd(input int code, input int kind, input int status, input logic [31:0] ns,
                              output logic [9:0] ca, output logic [31:0] cv);
        logic [31:0] w [16];
        logic [63:0] prp;
        for (int i = 0; i < 16; i++) w[i] = 32'd0;
        prp  = code == 4 ? 64'h2000_0000 : code == 5 ? 64'h3000_0000 : 64'h1000_0000;
        w[0] = {16'(m_cid), 8'h00, code == 4 ? 8'h05 : code == 5 ? 8'h01 : 8'h06};
        if (code == 2 || code == 3) w[1] = ns;
        w[6]  = prp[31:0];
        w[7]  = prp[63:32];
        w[10] = code == 1 ? 32'd1 : code >= 4 ? 32'h003F_0001 : 32'd0;
        w[11] = code == 4 ? 32'd1 : code == 5 ? 32'h0001_0001 : 32'd0;
        for (int i = 0; i < 16; i++) sq_q.push_back('{32'(m_tail * 16 + i), w[i]});
        m_tail = (m_tail + 1) % 8;
        db_q.push_back('{32'h1000, 32'(m_tail)});
        ca = 10'd0;
        cv = 32'd0;
        if (kind == 2) done_q.push_back('{15'h7FFF, 1'b1});
        else begin
            ca = 10'(m_head * 4 + 3);
            cv = {15'(status), 1'(m_phase), 16'(m_cid)};
            m_head = (m_head + 1) % 8;
            if (m_head == 0) m_phase ^= 1;
            db_q.push_back('{32'h1004, 32'(m_head)});
            done_q.push_back('{15'(status), status != 0});
        end
        m_cid++;
    endtask

    task automatic wait_ack(input int n);
        int seen = 0, cyc = 0;
        while (seen < n && cyc < 600) begin
            @(negedge clk_in);
            cyc++;
            if (cmd_complete_ack) seen++;
        end
        chk("done_wait", 64'(seen), 64'(n));
        @(negedge clk_in);
    endtask

    // kind: 0 good, 1 error status, 2 no completion; decoy posts a stale-phase CQE first
    task automatic do_cmd(input int code, input int kind, input int status, input bit decoy);
        logic [9:0]  ca;
        logic [31:0] cv;
        if (config_data == 32'(code)) begin
            config_data = 32'd0;
            @(negedge clk_in);
        end
        nsid = $urandom;
        expect_cmd(code, kind, status, nsid, ca, cv);
        if (kind != 2) cq_mem[ca] = decoy ? {~cv[31:16], cv[15:0]} : cv;
        config_data = 32'(code);
        if (decoy) begin
            repeat (30) @(negedge clk_in);
            cq_mem[ca] = cv;
        end
        wait_ack(1);
        chk("idle_after", {62'd0, busy, cmd_complete}, 64'd1);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_bits"}, {55'd0, sq_wr_en, cq_rd_en, db_wr_en, seq_tail_done, seq_tail_done_ack,
                              cmd_complete, cmd_complete_ack, cmd_error, busy}, 64'd0);
        chk({name, "_bus"}, 64'(sq_wr_addr) | 64'(sq_wr_data) | 64'(cq_rd_addr) | 64'(db_addr)
                            | 64'(db_data) | 64'(cmd_status), 64'd0);
    endtask

    initial begin
        wr_t   e;
        done_t dn;
        logic  prev_sq_db = 1'b0;
        forever begin
            @(negedge clk_in);
            if (sq_wr_en) begin
                if (sq_q.size() == 0) begin
                    vecs++; errs++;
                    $display("FAIL sq_unexpected: got addr %h data %h expected no write", sq_wr_addr, sq_wr_data);
                end else begin
                    e = sq_q.pop_front();
                    chk("sq_wr", {32'(sq_wr_addr), sq_wr_data}, {e.a, e.d});
                    chk("build_flags", {62'd0, cmd_complete, cmd_error}, 64'd0);
                end
            end
            if (db_wr_en) begin
                if (db_q.size() == 0) begin
                    vecs++; errs++;
                    $display("FAIL db_unexpected: got addr %h data %h expected no write", db_addr, db_data);
                end else begin
                    e = db_q.pop_front();
                    chk("doorbell", {db_addr, db_data}, {e.a, e.d});
                end
            end
            if (prev_sq_db || seq_tail_done_ack)
                chk("tail_ack", {62'd0, seq_tail_done_ack, seq_tail_done}, {62'd0, prev_sq_db, 1'b1});
            prev_sq_db = db_wr_en && db_addr == 32'h1000;
            if (cmd_complete_ack) begin
                if (done_q.size() == 0) begin
                    vecs++; errs++;
                    $display("FAIL done_unexpected: got status %h expected no completion", cmd_status);
                end else begin
                    dn = done_q.pop_front();
                    chk("done", {47'd0, cmd_complete, cmd_status, cmd_error}, {47'd0, 1'b1, dn.st, dn.er});
                end
            end
        end
    end

    initial begin
        logic [9:0]  ca;
        logic [31:0] cv;
        int          code, kind, r;
        for (int i = 0; i < 1024; i++) cq_mem[i] = 32'd0;
        repeat (3) @(negedge clk_in);
        chk_zero("reset");
        resetb = 1'b0;
        @(negedge clk_in);
        do_cmd(1, 0, 0, 0);
        do_cmd(3, 0, 0, 0);
        do_cmd(4, 0, 0, 0);
        do_cmd(5, 0, 0, 0);
        config_data = 32'd7;
        @(negedge clk_in);
        chk("bad_pulse", {62'd0, cmd_error, busy}, 64'd2);
        @(negedge clk_in);
        chk("bad_clear", {62'd0, cmd_error, busy}, 64'd0);
        do_cmd(1, 1, 1, 0);
        do_cmd(2, 2, 0, 0);
        for (int n = 0; n < 20; n++) begin
            code = $urandom_range(1, 5);
            r    = $urandom_range(0, 9);
            kind = r < 7 ? 0 : r < 9 ? 1 : 2;
            do_cmd(code, kind, kind == 1 ? $urandom_range(1, 32766) : 0, kind != 2 && $urandom_range(0, 1) == 1);
        end
        config_data = 32'd0;
        @(negedge clk_in);
        expect_cmd(1, 0, 0, nsid, ca, cv);
        cq_mem[ca] = cv;
        expect_cmd(4, 0, 0, nsid, ca, cv);
        cq_mem[ca] = cv;
        config_data = 32'd1;
        repeat (5) @(negedge clk_in);
        config_data = 32'd4;
        wait_ack(2);
        config_data = 32'd0;
        @(negedge clk_in);
        expect_cmd(1, 0, 0, nsid, ca, cv);
        config_data = 32'd1;
        for (int n = 0; n < 100 && !(sq_wr_en && sq_wr_addr[3:0] == 4'd7); n++) @(negedge clk_in);
        chk("reached_dw7", {59'd0, sq_wr_en, sq_wr_addr[3:0]}, {59'd0, 1'b1, 4'd7});
        resetb      = 1'b1;
        config_data = 32'd0;
        @(negedge clk_in);
        chk_zero("mid_build_reset");
        chk("writes_left", 64'(sq_q.size()), 64'd8);
        sq_q.delete();
        db_q.delete();
        done_q.delete();
        m_tail = 0; m_head = 0; m_phase = 1; m_cid = 0;
        for (int i = 0; i < 1024; i++) cq_mem[i] = 32'd0;
        repeat (3) @(negedge clk_in);
        resetb = 1'b0;
        repeat (5) @(negedge clk_in);
        do_cmd(1, 0, 0, 1);
        chk("queues_drained", 64'(sq_q.size() + db_q.size() + done_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/nvme_admin_cmd_exec.md
NVME_ADMIN_CMD_EXEC -- requirements
Module: nvme_admin_cmd_exec

Interface
REQ-001 SHALL have parameters (name, default, meaning): ASQ_DEPTH, 8, admin SQ entries (power of 2, 2..64).
REQ-002 SHALL have ACQ_DEPTH, 8, admin CQ entries (power of 2, 2..64).
REQ-003 SHALL have IO_QSIZE, 16'd64, I/O queue entries; IO_QID, 16'd1, I/O queue id.
REQ-004 SHALL have IDENT_PRP, 64'h0000_0000_1000_0000, identify buffer; IOCQ_PRP, 64'h...2000_0000; IOSQ_PRP, 64'h...3000_0000.
REQ-005 SHALL have SQ0TDBL, 32'h1000, and CQ0HDBL, 32'h1004, doorbell register offsets.
REQ-006 SHALL have TIMEOUT, 32'd1_000_000, completion poll limit in cycles.
REQ-007 clk_in  in  1  clock; all logic on rising edge.
REQ-008 resetb  in  1  synchronous, active-high reset.
REQ-009 config_data  in  32  command code: 1 identify controller, 2/3 identify namespace, 4 create I/O CQ, 5 create I/O SQ.
REQ-010 nsid  in  32  namespace id for identify namespace.
REQ-011 sq_wr_en / sq_wr_addr / sq_wr_data  out  1/10/32  admin SQ dword write port, address = slot*16 + dword.
REQ-012 cq_rd_en / cq_rd_addr  out  1/10  admin CQ dword read port; cq_rd_data  in  32, valid 1 cycle after cq_rd_en.
REQ-013 db_wr_en / db_addr / db_data  out  1/32/32  doorbell register write, single cycle.
REQ-014 seq_tail_done, seq_tail_done_ack, cmd_complete, cmd_complete_ack  out  1  handshake to the init sequencer.
REQ-015 cmd_status  out  15  CQE status field of last command; cmd_error  out  1  status nonzero or timeout; busy  out  1.

Function
REQ-016 SHALL start a command when config_data differs from the last registered copy and is nonzero, only in IDLE; a change while not IDLE SHALL be latched and started on return to IDLE.
REQ-017 Codes outside 1..5 SHALL update the copy, not start a command, and pulse cmd_error one cycle.
REQ-018 States: IDLE -> BUILD -> DOORBELL -> POLL_RD -> POLL_CHK -> CQ_DB -> DONE -> IDLE.
REQ-019 BUILD SHALL write 16 dwords, one per cycle, dword 0 first, at slot sq_tail; unlisted dwords are 0.
REQ-020 DW0 = {cid[15:0], 8'h00, opcode}; opcode 0x06 identify, 0x05 create I/O CQ, 0x01 create I/O SQ.
REQ-021 DW1 = nsid input for codes 2/3, else 0; DW6/DW7 = PRP low/high per code (IDENT_PRP, IOCQ_PRP, IOSQ_PRP).
REQ-022 DW10 = 1 for code 1, 0 for codes 2/3, {IO_QSIZE-1, IO_QID} for codes 4/5.
REQ-023 DW11 = 32'h1 (contiguous, no interrupt) for code 4, {IO_QID, 16'h0001} for code 5.
REQ-024 DOORBELL SHALL advance sq_tail = (sq_tail+1) mod ASQ_DEPTH and write db_addr=SQ0TDBL, db_data=new tail in one cycle.
REQ-025 seq_tail_done SHALL rise the cycle after the doorbell write and stay high until DONE; seq_tail_done_ack SHALL pulse one cycle on its first cycle.
REQ-026 POLL_RD SHALL read CQE dword 3 at slot cq_head (addr cq_head*4+3); POLL_CHK SHALL accept when bit16 equals expected phase and bits[15:0] equal cid, else return to POLL_RD.
REQ-027 On accept: cmd_status = bits[31:17]; cq_head = (cq_head+1) mod ACQ_DEPTH; phase SHALL invert when cq_head wraps to 0.
REQ-028 CQ_DB SHALL write db_addr=CQ0HDBL, db_data=new cq_head.
REQ-029 DONE SHALL raise cmd_complete and pulse cmd_complete_ack in the same first cycle; cmd_complete stays high until the next command enters BUILD.
REQ-030 cid SHALL increment by 1 (16-bit wrap) per started command.
REQ-031 Poll counter reaching TIMEOUT SHALL go to DONE with cmd_error=1, cmd_status=15'h7FFF, no CQ head update or doorbell.
REQ-032 cmd_error SHALL clear when the next command enters BUILD; busy SHALL be high in every state except IDLE.

Reset
REQ-033 Reset SHALL force IDLE at any state, abandoning any command without further writes.
REQ-034 Reset values: all outputs 0, sq_tail 0, cq_head 0, expected phase 1, cid 0, last config copy 0, timeout counter 0.

Verification
REQ-035 config_data 0->1, CQE dw3 = 32'h0001_0000 at slot 0 -> 16 SQ writes with DW0=32'h0000_0006, DW10=1; doorbell 0x1000<=1; doorbell 0x1004<=1; cmd_complete and cmd_complete_ack high together one cycle.
REQ-036 Sequence 1,3,4,5 with good CQEs -> cid 0..3, code 4 DW10=32'h003F_0001, code 5 DW11=32'h0001_0001, sq_tail ends 4.
REQ-037 Nine commands with ACQ_DEPTH=8 -> ninth accepted only with phase bit 0, cq_head doorbell values 1..7,0,1.
REQ-038 CQE dw3 = 32'h0003_0000 (status 1) -> cmd_status=1, cmd_error=1, cmd_complete still asserted.
REQ-039 No CQE, TIMEOUT=100 -> DONE after ~100 cycles, cmd_error=1, cmd_status=15'h7FFF, no 0x1004 write.
REQ-040 resetb asserted mid-BUILD (dword 7) -> next cycle IDLE, sq_wr_en=0, all outputs 0, no doorbell write.
